csr_trap_unit: RTL and testbench
================================

# csr_trap_unit

Parametrised control/status register unit with trap sequencing for the out-of-order core. It holds the machine CSRs, performs write/set/clear CSR operations committed from the reservation-station path, and captures EPC/CAUSE on exceptions. It also sequences trap entry and `mret` return as a redirect-then-drain handshake with the front end. It sits beside the commit stage; the decode stage reads it combinationally.

## Interface
Parameters:
- XLEN, 32, data width of every CSR
- ADDR_W, 12, CSR address width
- CAUSE_W, 5, exception cause width
- NUM_SCRATCH, 4, number of scratch CSRs (1..16)
- TVEC_RESET, 32'h0000_0100, reset value of TVEC

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- rd_addr  in  ADDR_W  decode-stage read address
- rd_data  out  XLEN  combinational read data, 0 when unmapped
- rd_hit  out  1  rd_addr maps to an implemented CSR
- wr_en  in  1  commit a CSR operation this cycle
- wr_addr  in  ADDR_W  target CSR
- wr_op  in  2  00 write, 01 set (OR), 10 clear (AND-NOT), 11 no-op
- wr_data  in  XLEN  operand
- wr_illegal  out  1  combinational: wr_en to an unmapped or read-only address
- exc_valid  in  1  exception reported at commit
- exc_pc  in  XLEN  PC of faulting instruction
- exc_cause  in  CAUSE_W  cause code
- mret_valid  in  1  `mret` committed
- retire_count  in  2  instructions retired this cycle (0..2)
- flush_ack  in  1  pipeline drain complete
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  XLEN  redirect target
- trap_busy  out  1  state is REDIRECT or DRAIN

## Operation
- Address map: STATUS 0x300 (bit0 IE, bit1 PIE, other bits read 0, not writable); TVEC 0x305 (bits[1:0] read 0); EPC 0x341; CAUSE 0x342 (zero-extended CAUSE_W bits); SCRATCH i at 0x3C0+i; CYCLE 0xC00 and INSTRET 0xC02, both read-only.
- Write value: new = wr_data, old|wr_data, old&~wr_data, or old, selected by wr_op. Read-only and unmapped writes have no effect and raise wr_illegal.
- Read bypass: when an accepted write targets rd_addr in the same cycle, rd_data shows the post-operation value. Otherwise rd_data shows the registered value. CYCLE/INSTRET always show the registered value.
- CYCLE increments by 1 every cycle and INSTRET by retire_count every cycle. Both wrap modulo 2^XLEN.
- FSM states: IDLE, REDIRECT, DRAIN.
  - IDLE with exc_valid: EPC←exc_pc, CAUSE←exc_cause, PIE←IE, IE←0; go to REDIRECT with redirect_pc = TVEC.
  - IDLE with mret_valid and no exc_valid: IE←PIE, PIE←1; go to REDIRECT with redirect_pc = EPC.
  - REDIRECT: redirect_valid=1 for exactly one cycle; next state DRAIN.
  - DRAIN: hold until flush_ack=1, then go to IDLE on the next edge.
- Simultaneous events:
  - exc_valid beats mret_valid; the mret is dropped.
  - In the exception-accept cycle, a wr_en is honoured except to EPC/CAUSE/STATUS, where the trap update wins.
  - While trap_busy is high, wr_en, exc_valid and mret_valid are all ignored. Counters keep running.
- Reset values: STATUS, EPC, CAUSE, SCRATCH, CYCLE and INSTRET are 0; TVEC is TVEC_RESET; state is IDLE; redirect_valid, trap_busy and redirect_pc are 0.
- Reset asserted mid-trap returns the FSM to IDLE immediately, without waiting for a clock edge.

## Timing
- Read path is combinational, 0 cycles.
- CSR writes are visible in registered form the cycle after wr_en.
- Exception or mret at edge N sets the FSM to REDIRECT after N, so redirect_valid is high in cycle N+1. redirect_pc is registered and stable while redirect_valid is high.
- DRAIN begins in cycle N+2. A flush_ack in cycle M gives IDLE in cycle M+1. A flush_ack that arrives while in REDIRECT is ignored.
- Earliest back-to-back trap: the next exception is accepted in the first IDLE cycle.

## Test plan
- Reset → TVEC=0x100, STATUS=0, CYCLE=0. Write 0x305←0x2003 (op 00) → reads 0x2000. Set STATUS with 0x1 → IE=1.
- Bypass: wr_en set 0x3C1 with 0xF0 while rd_addr=0x3C1 and old value 0x0F → rd_data=0xFF in the same cycle.
- Exception with IE=1, exc_pc=0x40, cause=2 → next cycle redirect_valid=1 and redirect_pc=0x2000; EPC=0x40, CAUSE=2, IE=0, PIE=1. Then flush_ack after 3 DRAIN cycles → IDLE.
- exc_valid and mret_valid in the same cycle, together with a write to EPC of 0x99 → EPC holds exc_pc, the mret is ignored, redirect_pc=TVEC.
- Write to 0xC00 → wr_illegal=1 and CYCLE unaffected. retire_count=2 for 5 cycles → INSTRET=10. Preload CYCLE near 2^32−1 via force → it wraps to 0.
- Reset asserted during DRAIN → trap_busy falls to 0 without a clock edge and all CSRs return to reset values.

Source files
------------

// File: rtl/csr_trap_unit.sv
// Machine CSR file with a write/set/clear commit port and a redirect-then-drain
// sequencer for trap entry and mret return.
module csr_trap_unit #(
    parameter int                XLEN        = 32,
    parameter int                ADDR_W      = 12,
    parameter int                CAUSE_W     = 5,
    parameter int                NUM_SCRATCH = 4,
    parameter logic [XLEN-1:0]   TVEC_RESET  = XLEN'(32'h0000_0100)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [XLEN-1:0]      rd_data,
    output logic                 rd_hit,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [1:0]           wr_op,
    input  logic [XLEN-1:0]      wr_data,
    output logic                 wr_illegal,
    input  logic                 exc_valid,
    input  logic [XLEN-1:0]      exc_pc,
    input  logic [CAUSE_W-1:0]   exc_cause,
    input  logic                 mret_valid,
    input  logic [1:0]           retire_count,
    input  logic                 flush_ack,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    output logic                 trap_busy
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REDIRECT = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(12'h300);
    localparam logic [ADDR_W-1:0] A_TVEC    = ADDR_W'(12'h305);
    localparam logic [ADDR_W-1:0] A_EPC     = ADDR_W'(12'h341);
    localparam logic [ADDR_W-1:0] A_CAUSE   = ADDR_W'(12'h342);
    localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(12'h3C0);
    localparam logic [ADDR_W-1:0] A_CYCLE   = ADDR_W'(12'hC00);
    localparam logic [ADDR_W-1:0] A_INSTRET = ADDR_W'(12'hC02);

    logic [1:0]         state_q, state_d;
    logic               ie_q, ie_d, pie_q, pie_d;
    logic [XLEN-1:0]    tvec_q, tvec_d, epc_q, epc_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [XLEN-1:0]    scratch_q [NUM_SCRATCH];
    logic [XLEN-1:0]    scratch_d [NUM_SCRATCH];
    logic [XLEN-1:0]    cycle_q, cycle_d, instret_q, instret_d;
    logic               redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;

    logic [XLEN:0]      rd_look_s, wr_look_s;
    logic [XLEN-1:0]    wr_val_s;
    logic               idle_s, wr_ro_s, wr_ok_s, wr_eff_s;
    logic               exc_take_s, mret_take_s, trap_reg_s;

    function automatic logic [XLEN-1:0] csr_op(input logic [XLEN-1:0] old_v,
                                               input logic [XLEN-1:0] data,
                                               input logic [1:0]      op);
        logic [XLEN-1:0] r;
        case (op)
            OP_WRITE: r = data;
            OP_SET:   r = old_v | data;
            OP_CLEAR: r = old_v & ~data;
            default:  r = old_v;
        endcase
        return r;
    endfunction

    // Narrow a raw value to the bits the target CSR actually implements.
    function automatic logic [XLEN-1:0] csr_fit(input logic [ADDR_W-1:0] a,
                                                input logic [XLEN-1:0]   v);
        logic [XLEN-1:0] r;
        case (a)
            A_STATUS: r = {{(XLEN-2){1'b0}}, v[1:0]};
            A_TVEC:   r = {v[XLEN-1:2], 2'b00};
            A_CAUSE:  r = {{(XLEN-CAUSE_W){1'b0}}, v[CAUSE_W-1:0]};
            default:  r = v;
        endcase
        return r;
    endfunction

    // Returns {hit, registered value} for a CSR address.
    function automatic logic [XLEN:0] csr_lookup(input logic [ADDR_W-1:0] a);
        logic [XLEN:0] r;
        r = '0;
        case (a)
            A_STATUS:  r = {1'b1, {(XLEN-2){1'b0}}, pie_q, ie_q};
            A_TVEC:    r = {1'b1, tvec_q};
            A_EPC:     r = {1'b1, epc_q};
            A_CAUSE:   r = {1'b1, {(XLEN-CAUSE_W){1'b0}}, cause_q};
            A_CYCLE:   r = {1'b1, cycle_q};
            A_INSTRET: r = {1'b1, instret_q};
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (a == A_SCRATCH + ADDR_W'(i)) r = {1'b1, scratch_q[i]};
                    else                             r = r;
                end
            end
        endcase
        return r;
    endfunction

    // Write qualification, trap arbitration and the bypassed read port.
    always_comb begin
        idle_s      = (state_q == S_IDLE);
        exc_take_s  = idle_s & exc_valid;
        mret_take_s = idle_s & mret_valid & ~exc_valid;
        wr_look_s   = csr_lookup(wr_addr);
        rd_look_s   = csr_lookup(rd_addr);
        wr_ro_s     = (wr_addr == A_CYCLE) | (wr_addr == A_INSTRET);
        wr_ok_s     = wr_look_s[XLEN] & ~wr_ro_s;
        wr_illegal  = wr_en & ~wr_ok_s;
        trap_reg_s  = (wr_addr == A_STATUS) | (wr_addr == A_EPC) | (wr_addr == A_CAUSE);
        wr_eff_s    = wr_en & idle_s & wr_ok_s
                    & ~(exc_take_s & trap_reg_s)
                    & ~(mret_take_s & (wr_addr == A_STATUS));
        wr_val_s    = csr_fit(wr_addr, csr_op(wr_look_s[XLEN-1:0], wr_data, wr_op));
        rd_hit      = rd_look_s[XLEN];
        if (wr_eff_s && (wr_addr == rd_addr)) rd_data = wr_val_s;
        else                                  rd_data = rd_look_s[XLEN-1:0];
    end

    // Next-state for CSRs, counters and the trap sequencer.
    always_comb begin
        state_d          = state_q;
        ie_d             = ie_q;
        pie_d            = pie_q;
        tvec_d           = tvec_q;
        epc_d            = epc_q;
        cause_d          = cause_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        cycle_d          = cycle_q + XLEN'(1);
        instret_d        = instret_q + XLEN'(retire_count);
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (wr_eff_s && (wr_addr == A_SCRATCH + ADDR_W'(i))) scratch_d[i] = wr_val_s;
            else                                                 scratch_d[i] = scratch_q[i];
        end
        if (wr_eff_s) begin
            case (wr_addr)
                A_STATUS: begin ie_d = wr_val_s[0]; pie_d = wr_val_s[1]; end
                A_TVEC:   tvec_d  = wr_val_s;
                A_EPC:    epc_d   = wr_val_s;
                A_CAUSE:  cause_d = wr_val_s[CAUSE_W-1:0];
                default:  tvec_d  = tvec_q;
            endcase
        end else begin
            tvec_d = tvec_q;
        end
        case (state_q)
            S_IDLE: begin
                if (exc_valid) begin
                    epc_d            = exc_pc;
                    cause_d          = exc_cause;
                    pie_d            = ie_q;
                    ie_d             = 1'b0;
                    state_d          = S_REDIRECT;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = tvec_q;
                end else if (mret_valid) begin
                    ie_d             = pie_q;
                    pie_d            = 1'b1;
                    state_d          = S_REDIRECT;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = epc_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REDIRECT: state_d = S_DRAIN;
            S_DRAIN: begin
                if (flush_ack) state_d = S_IDLE;
                else           state_d = S_DRAIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset clears everything asynchronously, including mid-trap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            ie_q             <= 1'b0;
            pie_q            <= 1'b0;
            tvec_q           <= TVEC_RESET;
            epc_q            <= '0;
            cause_q          <= '0;
            cycle_q          <= '0;
            instret_q        <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
        end else begin
            state_q          <= state_d;
            ie_q             <= ie_d;
            pie_q            <= pie_d;
            tvec_q           <= tvec_d;
            epc_q            <= epc_d;
            cause_q          <= cause_d;
            cycle_q          <= cycle_d;
            instret_q        <= instret_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= scratch_d[i];
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign trap_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: CSR ops, read bypass, trap/mret sequencing,
// counters and asynchronous reset during a trap.
module tb_csr_trap_unit;

    logic        clk;
    logic        reset;
    logic [11:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [1:0]  wr_op;
    logic [31:0] wr_data;
    logic        wr_illegal;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic [4:0]  exc_cause;
    logic        mret_valid;
    logic [1:0]  retire_count;
    logic        flush_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_busy;

    csr_trap_unit dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_hit(rd_hit),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_op(wr_op), .wr_data(wr_data),
        .wr_illegal(wr_illegal),
        .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_cause(exc_cause),
        .mret_valid(mret_valid), .retire_count(retire_count), .flush_ack(flush_ack),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .trap_busy(trap_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        redir_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_cyc, m_ins;

    // Reference counters: cycles and retired instructions since reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cyc <= 32'd0;
            m_ins <= 32'd0;
        end else begin
            m_cyc <= m_cyc + 32'd1;
            m_ins <= m_ins + {30'd0, retire_count};
        end
    end

    task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(string tag, logic [31:0] v);
        exp_q.push_back('{tag: tag, val: v});
    endtask

    task automatic pop_chk(logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_val(e.tag, obs, e.val);
        end
    endtask

    task automatic rd_chk(string tag, logic [11:0] a, logic [31:0] e);
        rd_addr = a;
        push_exp(tag, e);
        #1;
        pop_chk(rd_data);
    endtask

    task automatic sig_chk(string tag, logic [31:0] obs, logic [31:0] e);
        push_exp(tag, e);
        pop_chk(obs);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_wr(logic [11:0] a, logic [1:0] op, logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_op = op; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    // Each redirect pulse must match the next expected target, in order.
    always @(negedge clk) begin : redir_mon
        exp_t e;
        if (redirect_valid === 1'b1) begin
            if (redir_q.size() == 0) begin
                check_val("redirect_unexpected", 32'd1, 32'd0);
            end else begin
                e = redir_q.pop_front();
                check_val(e.tag, redirect_pc, e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; rd_addr = 12'h000; wr_en = 1'b0; wr_addr = 12'h000;
        wr_op = 2'b11; wr_data = 32'd0; exc_valid = 1'b0; exc_pc = 32'd0;
        exc_cause = 5'd0; mret_valid = 1'b0; retire_count = 2'd0; flush_ack = 1'b0;
        repeat (2) @(negedge clk);

        rd_chk("rst_tvec", 12'h305, 32'h0000_0100);
        rd_chk("rst_status", 12'h300, 32'd0);
        rd_chk("rst_cycle", 12'hC00, 32'd0);
        sig_chk("rst_busy", {31'd0, trap_busy}, 32'd0);
        sig_chk("rst_redir_v", {31'd0, redirect_valid}, 32'd0);
        sig_chk("rst_redir_pc", redirect_pc, 32'd0);
        reset = 1'b0;

        // TVEC write drops the low two bits; bypass shows it in the same cycle.
        wr_en = 1'b1; wr_addr = 12'h305; wr_op = 2'b00; wr_data = 32'h0000_2003;
        rd_chk("tvec_bypass", 12'h305, 32'h0000_2000);
        sig_chk("tvec_legal", {31'd0, wr_illegal}, 32'd0);
        step();
        wr_en = 1'b0;
        rd_chk("tvec_reg", 12'h305, 32'h0000_2000);

        do_wr(12'h300, 2'b01, 32'h0000_0001);
        rd_chk("status_ie", 12'h300, 32'h0000_0001);

        do_wr(12'h3C1, 2'b00, 32'h0000_000F);
        wr_en = 1'b1; wr_addr = 12'h3C1; wr_op = 2'b01; wr_data = 32'h0000_00F0;
        rd_chk("scr_set_bypass", 12'h3C1, 32'h0000_00FF);
        sig_chk("scr_hit", {31'd0, rd_hit}, 32'd1);
        step();
        wr_en = 1'b0;
        rd_chk("scr_set_reg", 12'h3C1, 32'h0000_00FF);
        do_wr(12'h3C1, 2'b10, 32'h0000_000F);
        rd_chk("scr_clear", 12'h3C1, 32'h0000_00F0);
        do_wr(12'h3C1, 2'b11, 32'hFFFF_FFFF);
        rd_chk("scr_noop", 12'h3C1, 32'h0000_00F0);
        do_wr(12'h342, 2'b00, 32'hFFFF_FFFF);
        rd_chk("cause_trunc", 12'h342, 32'h0000_001F);

        rd_chk("unmapped_data", 12'h123, 32'd0);
        sig_chk("unmapped_hit", {31'd0, rd_hit}, 32'd0);
        rd_chk("scr4_data", 12'h3C4, 32'd0);
        sig_chk("scr4_hit", {31'd0, rd_hit}, 32'd0);

        // Exception with a concurrent scratch write, which must still land.
        exc_valid = 1'b1; exc_pc = 32'h40; exc_cause = 5'd2;
        wr_en = 1'b1; wr_addr = 12'h3C3; wr_op = 2'b00; wr_data = 32'h55;
        redir_q.push_back('{tag: "redir_exc", val: 32'h0000_2000});
        step();
        exc_valid = 1'b0; wr_en = 1'b0;
        sig_chk("exc_redir_v", {31'd0, redirect_valid}, 32'd1);
        sig_chk("exc_busy", {31'd0, trap_busy}, 32'd1);
        flush_ack = 1'b1;
        exc_valid = 1'b1; exc_pc = 32'hBAD;
        rd_chk("exc_epc", 12'h341, 32'h40);
        rd_chk("exc_cause", 12'h342, 32'd2);
        rd_chk("exc_status", 12'h300, 32'h2);
        rd_chk("exc_scr3", 12'h3C3, 32'h55);
        step();
        flush_ack = 1'b0; exc_valid = 1'b0;
        sig_chk("drain_redir_v", {31'd0, redirect_valid}, 32'd0);
        sig_chk("drain_busy", {31'd0, trap_busy}, 32'd1);
        do_wr(12'h3C0, 2'b00, 32'h77);
        rd_chk("busy_wr_ignored", 12'h3C0, 32'd0);
        rd_chk("busy_exc_ignored", 12'h341, 32'h40);
        step();
        sig_chk("drain3_busy", {31'd0, trap_busy}, 32'd1);
        flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;
        sig_chk("drain_done", {31'd0, trap_busy}, 32'd0);

        mret_valid = 1'b1;
        redir_q.push_back('{tag: "redir_mret", val: 32'h40});
        step();
        mret_valid = 1'b0;
        sig_chk("mret_redir_v", {31'd0, redirect_valid}, 32'd1);
        rd_chk("mret_status", 12'h300, 32'h3);
        step();
        flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;

        // Exception, mret and an EPC write together: the exception wins everything.
        exc_valid = 1'b1; mret_valid = 1'b1; exc_pc = 32'h80; exc_cause = 5'd5;
        wr_en = 1'b1; wr_addr = 12'h341; wr_op = 2'b00; wr_data = 32'h99;
        redir_q.push_back('{tag: "redir_simul", val: 32'h0000_2000});
        rd_chk("simul_no_bypass", 12'h341, 32'h40);
        step();
        exc_valid = 1'b0; mret_valid = 1'b0; wr_en = 1'b0;
        rd_chk("simul_epc", 12'h341, 32'h80);
        rd_chk("simul_cause", 12'h342, 32'd5);
        rd_chk("simul_status", 12'h300, 32'h2);
        step();
        flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;
        sig_chk("b2b_idle", {31'd0, trap_busy}, 32'd0);
        exc_valid = 1'b1; exc_pc = 32'hC0; exc_cause = 5'd3;
        redir_q.push_back('{tag: "redir_b2b", val: 32'h0000_2000});
        step();
        exc_valid = 1'b0;
        sig_chk("b2b_redir_v", {31'd0, redirect_valid}, 32'd1);
        rd_chk("b2b_epc", 12'h341, 32'hC0);
        rd_chk("b2b_status", 12'h300, 32'd0);
        step();
        sig_chk("redir_one_cycle", {31'd0, redirect_valid}, 32'd0);
        flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;

        wr_en = 1'b1; wr_addr = 12'hC00; wr_op = 2'b00; wr_data = 32'd0;
        #1;
        sig_chk("ill_cycle", {31'd0, wr_illegal}, 32'd1);
        rd_chk("ill_cycle_val", 12'hC00, m_cyc);
        wr_addr = 12'hC02;
        #1;
        sig_chk("ill_instret", {31'd0, wr_illegal}, 32'd1);
        wr_addr = 12'h7FF;
        #1;
        sig_chk("ill_unmapped", {31'd0, wr_illegal}, 32'd1);
        wr_addr = 12'hC00;
        step();
        wr_en = 1'b0;
        rd_chk("cycle_after_ill", 12'hC00, m_cyc);

        // Reset mid-DRAIN, between clock edges.
        exc_valid = 1'b1; exc_pc = 32'h1C; exc_cause = 5'd1;
        redir_q.push_back('{tag: "redir_pre_rst", val: 32'h0000_2000});
        step();
        exc_valid = 1'b0;
        step();
        sig_chk("pre_rst_busy", {31'd0, trap_busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        sig_chk("async_rst_busy", {31'd0, trap_busy}, 32'd0);
        sig_chk("async_rst_rpc", redirect_pc, 32'd0);
        rd_chk("rst2_tvec", 12'h305, 32'h0000_0100);
        rd_chk("rst2_epc", 12'h341, 32'd0);
        rd_chk("rst2_status", 12'h300, 32'd0);
        rd_chk("rst2_scr1", 12'h3C1, 32'd0);
        rd_chk("rst2_cycle", 12'hC00, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        retire_count = 2'd2;
        repeat (5) step();
        retire_count = 2'd0;
        rd_chk("instret_10", 12'hC02, 32'd10);
        rd_chk("instret_model", 12'hC02, m_ins);

        force dut.cycle_q = 32'hFFFF_FFFE;
        #1 release dut.cycle_q;
        step();
        rd_chk("cycle_max", 12'hC00, 32'hFFFF_FFFF);
        step();
        rd_chk("cycle_wrap", 12'hC00, 32'd0);

        check_val("redir_pending", redir_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
